// File: rtl/lib_regbank_pkg.sv
// Shared constants for the PL-side local register bank: byte offsets of the
// register map, the default ID word and the value returned for unmapped reads.
package lib_regbank_pkg;

    localparam int unsigned ADDR_ID         = 32'h000;
    localparam int unsigned ADDR_SCRATCH    = 32'h004;
    localparam int unsigned ADDR_PULSE      = 32'h008;
    localparam int unsigned ADDR_IRQ_STATUS = 32'h00C;
    localparam int unsigned ADDR_IRQ_ENABLE = 32'h010;
    localparam int unsigned ADDR_TIMESTAMP  = 32'h014;
    localparam int unsigned ADDR_CMD        = 32'h018;
    localparam int unsigned BASE_CTRL       = 32'h100;
    localparam int unsigned BASE_STAT       = 32'h200;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h4C52_0100;
    localparam logic [31:0] RD_UNMAPPED      = 32'h0000_0000;

endpackage

// File: rtl/lib_irq_w1c.sv
// Interrupt block: rising-edge detect on irq_in, write-1-to-clear status
// (set wins over clear), enable mask and registered level interrupt.
module lib_irq_w1c #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             clr_wen,
    input  logic [N_IRQ-1:0] clr_data,
    input  logic             en_wen,
    input  logic [N_IRQ-1:0] en_data,
    output logic [N_IRQ-1:0] status,
    output logic [N_IRQ-1:0] enable,
    output logic             irq_out
);

    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] clr_mask;
    logic [N_IRQ-1:0] set_mask;

    assign clr_mask = clr_wen ? clr_data : '0;
    assign set_mask = irq_in & ~irq_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= '0;
            status   <= '0;
            enable   <= '0;
            irq_out  <= 1'b0;
        end else begin
            irq_prev <= irq_in;
            // OR-ing the set term last lets a new edge survive a same-cycle clear
            status   <= (status & ~clr_mask) | set_mask;
            if (en_wen) begin
                enable <= en_data;
            end
            irq_out  <= |(status & enable);
        end
    end

endmodule

// File: rtl/lib_local_regbank.sv
// PL-side register bank behind the AXI-lite-to-local bridge.
// Optional build macro LIB_REGBANK_SHADOW_EN: CTRL writes land in shadows, committed by CMD bit0.
module lib_local_regbank
    import lib_regbank_pkg::*;
#(
    parameter int               AXI_AW   = 12,
    parameter int               AXI_DW   = 32,
    parameter int               N_CTRL   = 8,
    parameter int               N_STAT   = 8,
    parameter int               N_IRQ    = 8,
    parameter logic [AXI_DW-1:0] ID_VALUE = AXI_DW'(DEFAULT_ID_VALUE)
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESET,
    input  logic                     ps_to_pl_wen,
    input  logic [AXI_AW-1:0]        ps_to_pl_addr,
    input  logic [AXI_DW-1:0]        ps_to_pl_data,
    input  logic                     pl_to_ps_ren,
    input  logic [AXI_AW-1:0]        pl_to_ps_addr,
    output logic [AXI_DW-1:0]        pl_to_ps_data,
    output logic [N_CTRL*AXI_DW-1:0] ctrl_out,
    input  logic [N_STAT*AXI_DW-1:0] stat_in,
    output logic [AXI_DW-1:0]        pulse_out,
    input  logic [N_IRQ-1:0]         irq_in,
    output logic                     irq_out
);

    localparam int WW = AXI_AW - 2;

    localparam logic [WW-1:0] W_ID         = WW'(ADDR_ID >> 2);
    localparam logic [WW-1:0] W_SCRATCH    = WW'(ADDR_SCRATCH >> 2);
    localparam logic [WW-1:0] W_PULSE      = WW'(ADDR_PULSE >> 2);
    localparam logic [WW-1:0] W_IRQ_STATUS = WW'(ADDR_IRQ_STATUS >> 2);
    localparam logic [WW-1:0] W_IRQ_ENABLE = WW'(ADDR_IRQ_ENABLE >> 2);
    localparam logic [WW-1:0] W_TIMESTAMP  = WW'(ADDR_TIMESTAMP >> 2);
    localparam logic [WW-1:0] W_CMD        = WW'(ADDR_CMD >> 2);
    localparam logic [WW-1:0] W_CTRL       = WW'(BASE_CTRL >> 2);
    localparam logic [WW-1:0] W_STAT       = WW'(BASE_STAT >> 2);

    logic [WW-1:0]     wr_word;
    logic [WW-1:0]     rd_word;
    logic              wr_scratch;
    logic              wr_pulse;
    logic              wr_irq_status;
    logic              wr_irq_enable;
    logic              wr_timestamp;
    logic              wr_cmd;
    logic              unused_addr_lsbs;

    logic [AXI_DW-1:0] scratch;
    logic [31:0]       timestamp;
    logic [AXI_DW-1:0] ctrl_q [N_CTRL];
`ifdef LIB_REGBANK_SHADOW_EN
    logic [AXI_DW-1:0] shadow [N_CTRL];
`endif
    logic [N_IRQ-1:0]  irq_status;
    logic [N_IRQ-1:0]  irq_enable;
    logic [AXI_DW-1:0] rd_value;

    // Byte-lane bits are ignored: every register is a full word.
    assign wr_word          = ps_to_pl_addr[AXI_AW-1:2];
    assign rd_word          = pl_to_ps_addr[AXI_AW-1:2];
    assign unused_addr_lsbs = ^{ps_to_pl_addr[1:0], pl_to_ps_addr[1:0]};

    assign wr_scratch    = ps_to_pl_wen && (wr_word == W_SCRATCH);
    assign wr_pulse      = ps_to_pl_wen && (wr_word == W_PULSE);
    assign wr_irq_status = ps_to_pl_wen && (wr_word == W_IRQ_STATUS);
    assign wr_irq_enable = ps_to_pl_wen && (wr_word == W_IRQ_ENABLE);
    assign wr_timestamp  = ps_to_pl_wen && (wr_word == W_TIMESTAMP);
    assign wr_cmd        = ps_to_pl_wen && (wr_word == W_CMD);

    lib_irq_w1c #(
        .N_IRQ (N_IRQ)
    ) u_irq (
        .clk      (S_AXI_ACLK),
        .rst      (S_AXI_ARESET),
        .irq_in   (irq_in),
        .clr_wen  (wr_irq_status),
        .clr_data (ps_to_pl_data[N_IRQ-1:0]),
        .en_wen   (wr_irq_enable),
        .en_data  (ps_to_pl_data[N_IRQ-1:0]),
        .status   (irq_status),
        .enable   (irq_enable),
        .irq_out  (irq_out)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            scratch       <= '0;
            pulse_out     <= '0;
            timestamp     <= '0;
            pl_to_ps_data <= '0;
            for (int i = 0; i < N_CTRL; i++) begin
                ctrl_q[i] <= '0;
`ifdef LIB_REGBANK_SHADOW_EN
                shadow[i] <= '0;
`endif
            end
        end else begin
            if (wr_scratch) begin
                scratch <= ps_to_pl_data;
            end
            pulse_out <= wr_pulse ? ps_to_pl_data : '0;
            timestamp <= wr_timestamp ? 32'd0 : timestamp + 32'd1;
            for (int i = 0; i < N_CTRL; i++) begin
`ifdef LIB_REGBANK_SHADOW_EN
                // Commit reads the shadow before this cycle's write lands in it
                if (wr_cmd && ps_to_pl_data[0]) begin
                    ctrl_q[i] <= shadow[i];
                end
                if (ps_to_pl_wen && (wr_word == W_CTRL + WW'(i))) begin
                    shadow[i] <= ps_to_pl_data;
                end
`else
                if (ps_to_pl_wen && (wr_word == W_CTRL + WW'(i))) begin
                    ctrl_q[i] <= ps_to_pl_data;
                end
`endif
            end
            if (pl_to_ps_ren) begin
                pl_to_ps_data <= rd_value;
            end
        end
    end

`ifndef LIB_REGBANK_SHADOW_EN
    logic unused_cmd;
    assign unused_cmd = wr_cmd;
`endif

    // Read decode sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rd_value = AXI_DW'(RD_UNMAPPED);
        case (rd_word)
            W_ID:         rd_value = ID_VALUE;
            W_SCRATCH:    rd_value = scratch;
            W_IRQ_STATUS: rd_value = AXI_DW'(irq_status);
            W_IRQ_ENABLE: rd_value = AXI_DW'(irq_enable);
            W_TIMESTAMP:  rd_value = AXI_DW'(timestamp);
            default:      ;
        endcase
        for (int i = 0; i < N_CTRL; i++) begin
            if (rd_word == W_CTRL + WW'(i)) begin
`ifdef LIB_REGBANK_SHADOW_EN
                rd_value = shadow[i];
`else
                rd_value = ctrl_q[i];
`endif
            end
        end
        for (int i = 0; i < N_STAT; i++) begin
            if (rd_word == W_STAT + WW'(i)) begin
                rd_value = stat_in[i*AXI_DW +: AXI_DW];
            end
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < N_CTRL; i++) begin
            ctrl_out[i*AXI_DW +: AXI_DW] = ctrl_q[i];
        end
    end

endmodule

// File: tb/tb_lib_local_regbank.sv
// Directed bench for lib_local_regbank; expected values are hand-computed constants.
module tb_lib_local_regbank;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NC = 8;
    localparam int NS = 8;
    localparam int NI = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic              ren;
    logic [AW-1:0]     raddr;
    logic [DW-1:0]     rdata;
    logic [NC*DW-1:0]  ctrl_out;
    logic [NS*DW-1:0]  stat_in;
    logic [DW-1:0]     pulse_out;
    logic [NI-1:0]     irq_in;
    logic              irq_out;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] rd;

    always #5 clk = ~clk;

    lib_local_regbank #(
        .AXI_AW (AW),
        .AXI_DW (DW),
        .N_CTRL (NC),
        .N_STAT (NS),
        .N_IRQ  (NI)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .ps_to_pl_wen  (wen),
        .ps_to_pl_addr (waddr),
        .ps_to_pl_data (wdata),
        .pl_to_ps_ren  (ren),
        .pl_to_ps_addr (raddr),
        .pl_to_ps_data (rdata),
        .ctrl_out      (ctrl_out),
        .stat_in       (stat_in),
        .pulse_out     (pulse_out),
        .irq_in        (irq_in),
        .irq_out       (irq_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Strobe held for one cycle; returns at the negedge after the write edge.
    task automatic reg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wen = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic reg_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        ren = 1'b1; raddr = a;
        @(negedge clk);
        ren = 1'b0;
        d = rdata;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        ren = 1'b0; raddr = '0; stat_in = '0; irq_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset_rdata", rdata, 32'h0);
        check("reset_irq_out", {31'b0, irq_out}, 32'h0);
        check("reset_pulse", pulse_out, 32'h0);
        check("reset_ctrl0", ctrl_out[0 +: 32], 32'h0);

        reg_read(12'h000, rd); check("rd_id", rd, 32'h4C52_0100);
        reg_read(12'h004, rd); check("rd_scratch_rst", rd, 32'h0);
        reg_read(12'h00C, rd); check("rd_irq_status_rst", rd, 32'h0);
        reg_read(12'h100, rd); check("rd_ctrl0_rst", rd, 32'h0);

        reg_write(12'h000, 32'hDEAD_BEEF);
        reg_read(12'h000, rd); check("id_read_only", rd, 32'h4C52_0100);

        reg_write(12'h104, 32'hA5A5_5A5A);
        check("ctrl1_out", ctrl_out[32 +: 32], 32'hA5A5_5A5A);
        reg_read(12'h104, rd); check("rd_ctrl1", rd, 32'hA5A5_5A5A);
        reg_read(12'h107, rd); check("rd_ctrl1_lsbs", rd, 32'hA5A5_5A5A);
        reg_read(12'h300, rd); check("rd_unmapped", rd, 32'h0);

        // Same-cycle write and read of SCRATCH returns the old value
        reg_write(12'h004, 32'h0000_0011);
        @(negedge clk);
        wen = 1'b1; waddr = 12'h004; wdata = 32'h0000_0022;
        ren = 1'b1; raddr = 12'h004;
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        check("rw_same_addr", rdata, 32'h0000_0011);
        reg_read(12'h004, rd); check("rd_scratch_new", rd, 32'h0000_0022);

        reg_write(12'h008, 32'h0000_0081);
        check("pulse_on", pulse_out, 32'h0000_0081);
        @(negedge clk);
        check("pulse_off", pulse_out, 32'h0);
        @(negedge clk);
        wen = 1'b1; waddr = 12'h008; wdata = 32'h1;
        @(negedge clk);
        wdata = 32'h2;
        check("pulse_b2b_1", pulse_out, 32'h1);
        @(negedge clk);
        wen = 1'b0;
        check("pulse_b2b_2", pulse_out, 32'h2);
        @(negedge clk);
        check("pulse_b2b_off", pulse_out, 32'h0);
        reg_read(12'h008, rd); check("rd_pulse", rd, 32'h0);

        stat_in[2*32 +: 32] = 32'h1234_5678;
        reg_read(12'h208, rd); check("rd_stat2", rd, 32'h1234_5678);
        reg_read(12'h220, rd); check("rd_stat_oob", rd, 32'h0);

        reg_write(12'h010, 32'h0000_0001);
        reg_read(12'h010, rd); check("rd_irq_enable", rd, 32'h1);
        @(negedge clk);
        irq_in = 8'h01;
        @(negedge clk);
        check("irq_out_lag", {31'b0, irq_out}, 32'h0);
        @(negedge clk);
        check("irq_out_set", {31'b0, irq_out}, 32'h1);
        reg_read(12'h00C, rd); check("irq_status_set", rd, 32'h1);

        reg_write(12'h00C, 32'h0000_0001);
        reg_read(12'h00C, rd); check("irq_status_clr", rd, 32'h0);
        check("irq_out_clr", {31'b0, irq_out}, 32'h0);
        repeat (3) @(negedge clk);
        reg_read(12'h00C, rd); check("irq_no_reset_level", rd, 32'h0);

        irq_in = 8'h00;
        @(negedge clk);
        irq_in = 8'h01;
        wen = 1'b1; waddr = 12'h00C; wdata = 32'h1;
        @(negedge clk);
        wen = 1'b0;
        reg_read(12'h00C, rd); check("irq_set_wins", rd, 32'h1);

        irq_in = 8'h09;
        reg_read(12'h00C, rd); check("irq_bit3", rd, 32'h9);
        reg_write(12'h00C, 32'hFFFF_FF08);
        reg_read(12'h00C, rd); check("irq_partial_clr", rd, 32'h1);

        reg_write(12'h014, 32'h0000_BEEF);
        repeat (10) @(negedge clk);
        reg_read(12'h014, rd);
        check("ts_range", {31'b0, (rd >= 32'd10) && (rd <= 32'd11)}, 32'h1);

        @(negedge clk);
        force dut.timestamp = 32'hFFFF_FFFF;
        ren = 1'b1; raddr = 12'h014;
        #1 release dut.timestamp;
        @(negedge clk);
        check("ts_max", rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        ren = 1'b0;
        check("ts_wrap", rdata, 32'h0);

`ifdef LIB_REGBANK_SHADOW_EN
        reg_write(12'h100, 32'h0000_0055);
        check("shadow_hold", ctrl_out[0 +: 32], 32'h0);
        reg_read(12'h100, rd); check("rd_shadow", rd, 32'h0000_0055);
        reg_write(12'h018, 32'h0000_0001);
        check("shadow_commit", ctrl_out[0 +: 32], 32'h0000_0055);
`else
        reg_write(12'h100, 32'h0000_0055);
        check("ctrl0_direct", ctrl_out[0 +: 32], 32'h0000_0055);
        reg_write(12'h018, 32'h0000_0001);
        check("cmd_noop", ctrl_out[0 +: 32], 32'h0000_0055);
`endif
        reg_read(12'h018, rd); check("rd_cmd", rd, 32'h0);

        // Reset while a read is in flight
        @(negedge clk);
        rst = 1'b1; ren = 1'b1; raddr = 12'h000;
        @(negedge clk);
        rst = 1'b0; ren = 1'b0;
        check("rst_pending_read", rdata, 32'h0);
        check("rst_ctrl1", ctrl_out[32 +: 32], 32'h0);
        reg_read(12'h004, rd); check("rst_scratch", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lib_local_regbank.md
Name: lib_local_regbank

Overview:
- Register bank on the PL side of the AXI-lite-to-local bridge. Consumes the bridge's write strobe, address and data (ps_to_pl_*), and drives the read data (pl_to_ps_data) one cycle after the read enable.
- Provides ID, scratch, self-clearing pulse, write-1-to-clear (W1C) interrupt and free-running timestamp registers.
- Also provides N_CTRL read/write control words to fabric and N_STAT read-only status words from fabric.

Parameters:
- AXI_AW, 12: local address width, byte addressing.
- AXI_DW, 32: data width.
- N_CTRL, 8: number of control registers, 1..64.
- N_STAT, 8: number of status registers, 1..64.
- N_IRQ, 8: number of interrupt sources, 1..AXI_DW.
- ID_VALUE, 32'h4C52_0100: constant returned at ID register.

Ports:
- S_AXI_ACLK  in  1  single clock, shared with the bridge.
- S_AXI_ARESET  in  1  synchronous reset, active-high.
- ps_to_pl_wen  in  1  one-cycle write strobe.
- ps_to_pl_addr  in  AXI_AW  write byte address.
- ps_to_pl_data  in  AXI_DW  write data.
- pl_to_ps_ren  in  1  one-cycle read strobe.
- pl_to_ps_addr  in  AXI_AW  read byte address.
- pl_to_ps_data  out  AXI_DW  registered read data.
- ctrl_out  out  N_CTRL*AXI_DW  control words; word i at [i*AXI_DW +: AXI_DW].
- stat_in  in  N_STAT*AXI_DW  status words, synchronous to S_AXI_ACLK.
- pulse_out  out  AXI_DW  one-cycle pulses.
- irq_in  in  N_IRQ  interrupt sources, synchronous; rising edge sets status.
- irq_out  out  1  level interrupt.

Behaviour:
- Decode uses word index addr[AXI_AW-1:2]; addr[1:0] is ignored.
- Address map:
  - 0x000 ID: read-only, returns ID_VALUE.
  - 0x004 SCRATCH: read/write.
  - 0x008 PULSE: write-only; reads return 0.
  - 0x00C IRQ_STATUS: W1C.
  - 0x010 IRQ_ENABLE: read/write, bits N_IRQ-1:0.
  - 0x014 TIMESTAMP: read-only counter; any write clears it.
  - 0x018 CMD: write-only, bit0 = commit (SHADOW feature only); reads return 0.
  - 0x100+4i CTRL[i]: read/write, i < N_CTRL.
  - 0x200+4i STAT[i]: read-only, returns stat_in word i.
- Unmapped reads return 0; unmapped writes and writes to read-only registers are ignored.
- Reset values: pl_to_ps_data=0, ctrl_out=0, pulse_out=0, irq_out=0; SCRATCH, IRQ_STATUS, IRQ_ENABLE and TIMESTAMP are 0; the irq_in edge-detect history is 0.
- Write latency: the target register holds the new value on the cycle after wen. CTRL[i] updates ctrl_out on that same cycle.
- Read latency: on a ren cycle, pl_to_ps_data registers the decoded value and is valid the next cycle. It holds until the next ren. This matches the bridge, which raises RVALID the cycle after ren and passes pl_to_ps_data through combinationally.
- Simultaneous write and read to the same address: the read returns the pre-write value.
- PULSE: a write drives pulse_out = wdata for exactly one cycle, then 0. Back-to-back writes produce back-to-back pulses.
- IRQ_STATUS:
  - Bit k sets when irq_in[k]=1 and its previous-cycle value was 0.
  - A write clears the bits where wdata=1.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Bits at N_IRQ and above read 0.
- irq_out is registered: |(IRQ_STATUS & IRQ_ENABLE), one cycle behind the status register.
- TIMESTAMP: increments every cycle and wraps 0xFFFF_FFFF to 0. A write loads 0 (next cycle reads 1). A read returns the value at the ren cycle.
- STAT[i]: stat_in is sampled on the ren cycle, with no extra synchronisation.
- Reset asserted mid-access: all state returns to reset values on the next edge. A pending read returns 0.

Optional Feature:
- Macro: LIB_REGBANK_SHADOW_EN.
- Defined:
  - CTRL writes go to shadow registers; CTRL reads return the shadow value.
  - ctrl_out copies all shadows atomically on the cycle after a CMD write with bit0=1.
  - A commit in the same cycle as a CTRL write uses the old shadow value for that word.
- Not defined: no shadow registers; CTRL writes reach ctrl_out directly, and CMD is a no-op.

Decomposition:
- Package lib_regbank_pkg holds:
  - address offset constants ADDR_ID, ADDR_SCRATCH, ADDR_PULSE, ADDR_IRQ_STATUS, ADDR_IRQ_ENABLE, ADDR_TIMESTAMP, ADDR_CMD, BASE_CTRL, BASE_STAT;
  - the default ID_VALUE;
  - the RD_UNMAPPED=0 constant.
- Sub-module lib_irq_w1c (width N_IRQ): edge detect, set-wins W1C status, enable mask, registered irq_out.

Test Plan:
- Reset, then read 0x000, 0x004, 0x00C, 0x100 -> read data 0x4C520100, 0, 0, 0; irq_out=0, pulse_out=0.
- Write 0xA5A5_5A5A to 0x104, then read 0x104 -> ctrl_out word1 = 0xA5A55A5A on the cycle after wen; read data 0xA5A55A5A the cycle after ren; read 0x300 (unmapped) -> 0.
- Write 0x0000_0081 to 0x008 -> pulse_out = 0x81 for exactly 1 cycle, then 0; read 0x008 -> 0.
- IRQ sequence:
  - Write 0x01 to 0x010; pulse irq_in[0] -> IRQ_STATUS=0x01, irq_out=1 one cycle later.
  - Hold irq_in[0] high and write 0x01 to 0x00C -> status clears; no re-set without a new rising edge.
  - Rising edge coincident with the clear -> status stays 1.
- TIMESTAMP: write any value to 0x014, idle 10 cycles, read -> count within the expected range (10 or 11 depending on the read cycle); force the count to 0xFFFFFFFF (bench force) -> next value 0.
- With LIB_REGBANK_SHADOW_EN: write 0x55 to 0x100 -> ctrl_out word0 stays 0 and a read of 0x100 returns 0x55; write 0x1 to 0x018 -> ctrl_out word0 = 0x55 the next cycle.
